vga_timing_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_controller_if.sv | 29 ++
 rtl/vga_pixel_divider.sv | 29 ++
 rtl/vga_timing_controller.sv | 117 +++++++++++
 tb/tb_vga_timing_controller.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and controller state encoding.
// Defaults describe 640x480 at 60 Hz from a 100 MHz system clock.
package vga_pkg;

    localparam int unsigned PIXEL_DIV   = 4;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned H_FRONT     = 16;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_BACK      = 48;
    localparam int unsigned H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned HSYNC_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HSYNC_END   = HSYNC_START + H_SYNC - 1;

    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned V_FRONT     = 10;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BACK      = 33;
    localparam int unsigned V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned VSYNC_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned FC_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_ctrl_state_t;

endpackage

// File: rtl/vga_timing_controller_if.sv
// Bundle between the VGA register file / pixel datapath and the timing controller.
interface vga_timing_controller_if;

    logic        enable_i;
    logic        pixel_pulse_o;
    logic [9:0]  hcount_o;
    logic [9:0]  vcount_o;
    logic        video_on_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        line_start_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic [15:0] frame_count_o;
    logic        busy_o;

    modport master (
        input  enable_i,
        output pixel_pulse_o, hcount_o, vcount_o, video_on_o, hsync_o, vsync_o,
        output line_start_o, frame_start_o, frame_done_o, frame_count_o, busy_o
    );

    modport slave (
        output enable_i,
        input  pixel_pulse_o, hcount_o, vcount_o, video_on_o, hsync_o, vsync_o,
        input  line_start_o, frame_start_o, frame_done_o, frame_count_o, busy_o
    );

endinterface

// File: rtl/vga_pixel_divider.sv
// Pixel-rate strobe from the system clock: one pulse every P_DIV cycles while running.
// Counter is held at zero while stopped so the first pulse lands P_DIV cycles after start.
module vga_pixel_divider #(
    parameter int unsigned P_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_run,
    output logic o_pulse
);

    localparam int unsigned CW = (P_DIV > 2) ? $clog2(P_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_cnt <= '0;
        end else if (!i_run || (r_div_cnt == LAST)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    assign o_pulse = i_run && (r_div_cnt == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: run/drain FSM, h/v counters, sync and window decodes.
// Disabling always finishes the current frame before returning to IDLE.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int unsigned P_PIXEL_DIV = PIXEL_DIV,
    parameter int unsigned P_H_ACTIVE  = H_ACTIVE,
    parameter int unsigned P_H_FRONT   = H_FRONT,
    parameter int unsigned P_H_SYNC    = H_SYNC,
    parameter int unsigned P_H_BACK    = H_BACK,
    parameter int unsigned P_V_ACTIVE  = V_ACTIVE,
    parameter int unsigned P_V_FRONT   = V_FRONT,
    parameter int unsigned P_V_SYNC    = V_SYNC,
    parameter int unsigned P_V_BACK    = V_BACK
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vga_timing_controller_if.master vga
);

    localparam int unsigned H_TOT = P_H_ACTIVE + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int unsigned V_TOT = P_V_ACTIVE + P_V_FRONT + P_V_SYNC + P_V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(P_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(P_V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(P_H_ACTIVE + P_H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(P_H_ACTIVE + P_H_FRONT + P_H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(P_V_ACTIVE + P_V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(P_V_ACTIVE + P_V_FRONT + P_V_SYNC - 1);

    vga_ctrl_state_t  r_state;
    vga_ctrl_state_t  w_state_nxt;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic [FC_W-1:0]  r_frame_count;
    logic             w_busy;
    logic             w_pixel_pulse;
    logic             w_h_last;
    logic             w_frame_done;

    assign w_busy       = (r_state != IDLE);
    assign w_h_last     = (r_hcount == H_LAST);
    assign w_frame_done = w_pixel_pulse && w_h_last && (r_vcount == V_LAST);

    vga_pixel_divider #(
        .P_DIV (P_PIXEL_DIV)
    ) u_pixel_divider (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_run   (w_busy),
        .o_pulse (w_pixel_pulse)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A disable landing on the last pixel of a frame needs no drain.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (vga.enable_i) w_state_nxt = RUN;
            RUN:     if (!vga.enable_i) w_state_nxt = w_frame_done ? IDLE : DRAIN;
            DRAIN: begin
                if (vga.enable_i) begin
                    w_state_nxt = RUN;
                end else if (w_frame_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Raster position advances only on pixel strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_count <= '0;
        end else begin
            if (!w_busy) begin
                r_hcount <= '0;
                r_vcount <= '0;
            end else if (w_pixel_pulse) begin
                if (w_h_last) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + CNT_W'(1);
                end else begin
                    r_hcount <= r_hcount + CNT_W'(1);
                end
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + FC_W'(1);
            end
        end
    end

    assign vga.pixel_pulse_o = w_pixel_pulse;
    assign vga.hcount_o      = r_hcount;
    assign vga.vcount_o      = r_vcount;
    assign vga.busy_o        = w_busy;
    assign vga.video_on_o    = w_busy && (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign vga.hsync_o       = !(w_busy && (r_hcount >= HS_START) && (r_hcount <= HS_END));
    assign vga.vsync_o       = !(w_busy && (r_vcount >= VS_START) && (r_vcount <= VS_END));
    assign vga.line_start_o  = w_pixel_pulse && (r_hcount == '0) && (r_vcount < V_ACT);
    assign vga.frame_start_o = w_pixel_pulse && (r_hcount == '0) && (r_vcount == '0);
    assign vga.frame_done_o  = w_frame_done;
    assign vga.frame_count_o = r_frame_count;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: a shrunken raster (16x12 pixels, div 4) for frame-level behaviour
// and a default-geometry instance for the real 640x480 line timing.
module tb_vga_timing_controller;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_fc = 0;

    always #5 clk = ~clk;

    vga_timing_controller_if if_s ();
    vga_timing_controller_if if_b ();

    // Small raster: H 8/2/3/3 -> 16 total, hsync h=10..12; V 6/2/2/2 -> 12 total, vsync v=8..9.
    vga_timing_controller #(
        .P_PIXEL_DIV (4),
        .P_H_ACTIVE  (8), .P_H_FRONT (2), .P_H_SYNC (3), .P_H_BACK (3),
        .P_V_ACTIVE  (6), .P_V_FRONT (2), .P_V_SYNC (2), .P_V_BACK (2)
    ) u_dut_small (
        .clk_i (clk),
        .rst_i (rst),
        .vga   (if_s)
    );

    vga_timing_controller u_dut_big (
        .clk_i (clk),
        .rst_i (rst),
        .vga   (if_b)
    );

    task automatic wait_pix(input int h, input int v, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (if_s.pixel_pulse_o && if_s.hcount_o == 10'(h) && if_s.vcount_o == 10'(v))
                found = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst = 1'b1;
        if_s.enable_i = 1'b0;
        if_b.enable_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flags = {if_s.pixel_pulse_o, if_s.video_on_o, if_s.line_start_o, if_s.frame_start_o,
                 if_s.frame_done_o, if_s.busy_o, if_s.hsync_o, if_s.vsync_o};
        checks++;
        if (flags !== 8'b0000_0011) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000011", flags);
        end
        checks++;
        if (if_s.hcount_o !== 10'd0 || if_s.vcount_o !== 10'd0 || if_s.frame_count_o !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got h=%0d v=%0d fc=%0d expected 0/0/0",
                               if_s.hcount_o, if_s.vcount_o, if_s.frame_count_o);
        end
        checks++;
        if (if_b.busy_o !== 1'b0 || if_b.hsync_o !== 1'b1 || if_b.vsync_o !== 1'b1) begin
            errors++; $display("FAIL reset_big: got busy=%b hs=%b vs=%b expected 0/1/1",
                               if_b.busy_o, if_b.hsync_o, if_b.vsync_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if_s.busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got busy=%b expected 0", if_s.busy_o);
        end
    endtask

    task automatic test_start();
        if_s.enable_i = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            checks++;
            if (if_s.busy_o !== 1'b1) begin
                errors++; $display("FAIL start_busy c%0d: got %b expected 1", cyc, if_s.busy_o);
            end
            checks++;
            if (if_s.pixel_pulse_o !== 1'((cyc % 4) == 0)) begin
                errors++; $display("FAIL start_pulse c%0d: got %b expected %0d", cyc,
                                   if_s.pixel_pulse_o, (cyc % 4) == 0);
            end
            checks++;
            if (if_s.frame_start_o !== 1'(cyc == 4)) begin
                errors++; $display("FAIL start_fstart c%0d: got %b expected %0d", cyc,
                                   if_s.frame_start_o, cyc == 4);
            end
            checks++;
            if (if_s.hcount_o !== 10'((cyc - 1) / 4) || if_s.video_on_o !== 1'b1) begin
                errors++; $display("FAIL start_h c%0d: got h=%0d von=%b expected h=%0d von=1", cyc,
                                   if_s.hcount_o, if_s.video_on_o, (cyc - 1) / 4);
            end
        end
    endtask

    task automatic test_geometry();
        bit found;
        int hs_low = 0, vs_low = 0, act = 0, act_clk = 0, lstart = 0, fstart = 0, fdone = 0;
        int fd_cyc = -1, hs_h = -1, hs_v = -1, vs_v = -1;
        wait_pix(15, 11, 800, found);
        checks++;
        if (!found || if_s.frame_done_o !== 1'b1 || if_s.frame_count_o !== 16'd0) begin
            errors++; $display("FAIL geo_first_done: got found=%0d fd=%b fc=%0d expected 1/1/0",
                               found, if_s.frame_done_o, if_s.frame_count_o);
        end
        exp_fc = 1;
        for (int cyc = 1; cyc <= 768; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if (if_s.frame_count_o !== 16'(exp_fc)) begin
                    errors++; $display("FAIL geo_fc1: got %0d expected %0d", if_s.frame_count_o, exp_fc);
                end
            end
            if (!if_s.hsync_o) begin
                hs_low++;
                if (hs_h < 0) begin hs_h = int'(if_s.hcount_o); hs_v = int'(if_s.vcount_o); end
            end
            if (!if_s.vsync_o) begin
                vs_low++;
                if (vs_v < 0) vs_v = int'(if_s.vcount_o);
            end
            if (if_s.video_on_o) act_clk++;
            if (if_s.pixel_pulse_o && if_s.video_on_o) act++;
            if (if_s.line_start_o) lstart++;
            if (if_s.frame_start_o) fstart++;
            if (if_s.frame_done_o) begin fdone++; fd_cyc = cyc; end
        end
        checks++;
        if (hs_low != 144 || hs_h != 10 || hs_v != 0) begin
            errors++; $display("FAIL geo_hsync: got low=%0d start_h=%0d v=%0d expected 144/10/0", hs_low, hs_h, hs_v);
        end
        checks++;
        if (vs_low != 128 || vs_v != 8) begin
            errors++; $display("FAIL geo_vsync: got low=%0d start_v=%0d expected 128/8", vs_low, vs_v);
        end
        checks++;
        if (act != 48 || act_clk != 192) begin
            errors++; $display("FAIL geo_active: got px=%0d clk=%0d expected 48/192", act, act_clk);
        end
        checks++;
        if (lstart != 6 || fstart != 1) begin
            errors++; $display("FAIL geo_markers: got lstart=%0d fstart=%0d expected 6/1", lstart, fstart);
        end
        checks++;
        if (fdone != 1 || fd_cyc != 768) begin
            errors++; $display("FAIL geo_period: got fdone=%0d at %0d expected 1 at 768", fdone, fd_cyc);
        end
        exp_fc = 2;
    endtask

    task automatic test_mid_disable();
        bit found;
        int pulses = 0;
        bit done = 1'b0;
        wait_pix(5, 3, 800, found);
        if_s.enable_i = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (if_s.pixel_pulse_o) pulses++;
            if (if_s.frame_done_o) done = 1'b1;
        end
        checks++;
        if (!found || !done || pulses != 138 || if_s.busy_o !== 1'b1) begin
            errors++; $display("FAIL drain_run: got found=%0d done=%0d pulses=%0d busy=%b expected 1/1/138/1",
                               found, done, pulses, if_s.busy_o);
        end
        @(negedge clk);
        exp_fc = 3;
        checks++;
        if (if_s.busy_o !== 1'b0 || if_s.hcount_o !== 10'd0 || if_s.vcount_o !== 10'd0) begin
            errors++; $display("FAIL drain_idle: got busy=%b h=%0d v=%0d expected 0/0/0",
                               if_s.busy_o, if_s.hcount_o, if_s.vcount_o);
        end
        checks++;
        if (if_s.frame_count_o !== 16'(exp_fc) || if_s.hsync_o !== 1'b1 || if_s.pixel_pulse_o !== 1'b0) begin
            errors++; $display("FAIL drain_fc: got fc=%0d hs=%b pp=%b expected %0d/1/0",
                               if_s.frame_count_o, if_s.hsync_o, if_s.pixel_pulse_o, exp_fc);
        end
    endtask

    task automatic test_reenable();
        bit found;
        bit done = 1'b0, busy_gap = 1'b0, jump = 1'b0, reen = 1'b0;
        int ph = 3, pv = 1, eh, ev;
        if_s.enable_i = 1'b1;
        wait_pix(3, 1, 800, found);
        if_s.enable_i = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (!if_s.busy_o) busy_gap = 1'b1;
            if (if_s.pixel_pulse_o) begin
                eh = (ph == 15) ? 0 : ph + 1;
                ev = (ph == 15) ? ((pv == 11) ? 0 : pv + 1) : pv;
                if (int'(if_s.hcount_o) != eh || int'(if_s.vcount_o) != ev) jump = 1'b1;
                ph = int'(if_s.hcount_o);
                pv = int'(if_s.vcount_o);
                if (ph == 0 && pv == 7) begin if_s.enable_i = 1'b1; reen = 1'b1; end
                if (if_s.frame_done_o) done = 1'b1;
            end
        end
        checks++;
        if (!found || !done || !reen || busy_gap || jump) begin
            errors++; $display("FAIL reen_cont: got found=%0d done=%0d reen=%0d gap=%0d jump=%0d expected 1/1/1/0/0",
                               found, done, reen, busy_gap, jump);
        end
        @(negedge clk);
        exp_fc = 4;
        checks++;
        if (if_s.busy_o !== 1'b1 || if_s.hcount_o !== 10'd0 || if_s.vcount_o !== 10'd0 ||
            if_s.frame_count_o !== 16'(exp_fc)) begin
            errors++; $display("FAIL reen_run: got busy=%b h=%0d v=%0d fc=%0d expected 1/0/0/%0d",
                               if_s.busy_o, if_s.hcount_o, if_s.vcount_o, if_s.frame_count_o, exp_fc);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        bit stray = 1'b0;
        wait_pix(15, 11, 800, found);
        if_s.enable_i = 1'b0;
        @(negedge clk);
        exp_fc = 5;
        checks++;
        if (!found || if_s.busy_o !== 1'b0 || if_s.hcount_o !== 10'd0 || if_s.frame_count_o !== 16'(exp_fc)) begin
            errors++; $display("FAIL same_cycle_idle: got found=%0d busy=%b h=%0d fc=%0d expected 1/0/0/%0d",
                               found, if_s.busy_o, if_s.hcount_o, if_s.frame_count_o, exp_fc);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_s.pixel_pulse_o || if_s.busy_o) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL same_cycle_quiet: got activity=1 expected 0");
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        if_s.enable_i = 1'b1;
        wait_pix(11, 8, 800, found);
        checks++;
        if (!found || if_s.hsync_o !== 1'b0 || if_s.vsync_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: got found=%0d hs=%b vs=%b expected 1/0/0",
                               found, if_s.hsync_o, if_s.vsync_o);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_fc = 0;
        checks++;
        if (if_s.busy_o !== 1'b0 || if_s.hcount_o !== 10'd0 || if_s.vcount_o !== 10'd0 ||
            if_s.frame_count_o !== 16'd0) begin
            errors++; $display("FAIL rstmid_state: got busy=%b h=%0d v=%0d fc=%0d expected 0/0/0/0",
                               if_s.busy_o, if_s.hcount_o, if_s.vcount_o, if_s.frame_count_o);
        end
        checks++;
        if (if_s.hsync_o !== 1'b1 || if_s.vsync_o !== 1'b1 || if_s.video_on_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_sync: got hs=%b vs=%b von=%b expected 1/1/0",
                               if_s.hsync_o, if_s.vsync_o, if_s.video_on_o);
        end
        rst = 1'b0;
        if_s.enable_i = 1'b0;
    endtask

    task automatic test_big_line();
        int act = 0, hs_low = 0, pulses = 0, hs_h = -1;
        bit vs_bad = 1'b0;
        if_b.enable_i = 1'b1;
        for (int cyc = 1; cyc <= 3204; cyc++) begin
            @(negedge clk);
            if (cyc <= 3200) begin
                if (if_b.pixel_pulse_o) pulses++;
                if (if_b.pixel_pulse_o && if_b.video_on_o) act++;
                if (!if_b.hsync_o) begin
                    hs_low++;
                    if (hs_h < 0) hs_h = int'(if_b.hcount_o);
                end
            end
            if (!if_b.vsync_o) vs_bad = 1'b1;
            if (cyc == 1) begin
                checks++;
                if (if_b.busy_o !== 1'b1 || if_b.pixel_pulse_o !== 1'b0) begin
                    errors++; $display("FAIL big_start: got busy=%b pp=%b expected 1/0", if_b.busy_o, if_b.pixel_pulse_o);
                end
            end
            if (cyc == 3200) begin
                checks++;
                if (if_b.hcount_o !== 10'd799 || if_b.vcount_o !== 10'd0 || if_b.pixel_pulse_o !== 1'b1 ||
                    if_b.frame_done_o !== 1'b0) begin
                    errors++; $display("FAIL big_line_end: got h=%0d v=%0d pp=%b fd=%b expected 799/0/1/0",
                                       if_b.hcount_o, if_b.vcount_o, if_b.pixel_pulse_o, if_b.frame_done_o);
                end
            end
            if (cyc == 3204) begin
                checks++;
                if (if_b.hcount_o !== 10'd0 || if_b.vcount_o !== 10'd1 || if_b.line_start_o !== 1'b1 ||
                    if_b.frame_start_o !== 1'b0) begin
                    errors++; $display("FAIL big_line2: got h=%0d v=%0d ls=%b fs=%b expected 0/1/1/0",
                                       if_b.hcount_o, if_b.vcount_o, if_b.line_start_o, if_b.frame_start_o);
                end
            end
        end
        checks++;
        if (pulses != 800 || act != 640) begin
            errors++; $display("FAIL big_pixels: got pulses=%0d active=%0d expected 800/640", pulses, act);
        end
        checks++;
        if (hs_low != 384 || hs_h != 656 || vs_bad) begin
            errors++; $display("FAIL big_hsync: got low=%0d start_h=%0d vs_low=%0d expected 384/656/0",
                               hs_low, hs_h, vs_bad);
        end
        if_b.enable_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_geometry();
        test_mid_disable();
        test_reenable();
        test_back_to_back();
        test_reset_mid();
        test_big_line();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
